// File: rtl/fifo_rd_packer_if.sv
// Bundle of the FIFO read port and the packed-word output channel used by
// fifo_rd_packer. The master side is the packer; the slave side is the
// environment (FIFO read port plus downstream word consumer).
interface fifo_rd_packer_if #(
    parameter int DATA_W = 8,
    parameter int PACK   = 4
);
    logic                   empty;
    logic [DATA_W-1:0]      rdata;
    logic                   rinc;
    logic [PACK*DATA_W-1:0] out_data;
    logic [PACK-1:0]        out_be;
    logic                   out_valid;
    logic                   out_ready;
    logic [15:0]            word_cnt;

    modport master (
        input  empty,
        input  rdata,
        input  out_ready,
        output rinc,
        output out_data,
        output out_be,
        output out_valid,
        output word_cnt
    );

    modport slave (
        output empty,
        output rdata,
        output out_ready,
        input  rinc,
        input  out_data,
        input  out_be,
        input  out_valid,
        input  word_cnt
    );
endinterface

// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: pops bytes from the asynchronous FIFO read port (rclk domain)
// and packs PACK of them into one output word, first byte in the low lane.
// At most one byte is ever in flight, so the assembly register never overflows
// and backpressure simply stalls rinc.
// Optional feature macro: FIFO_RD_TMO_EN -- when defined, a partial word that
// sits idle for TMO_CYC cycles with the FIFO empty is flushed with byte enables
// marking the valid lanes. When undefined, partial words wait for more bytes.
module fifo_rd_packer #(
    parameter int DATA_W  = 8,
    parameter int PACK    = 4,
    parameter int TMO_CYC = 16
) (
    input  logic              rclk,
    input  logic              rst,
    fifo_rd_packer_if.master  bus
);

    localparam int WW = PACK * DATA_W;
    localparam int CW = $clog2(PACK + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(PACK);
    localparam logic [CW-1:0] CNT_LAST = CW'(PACK - 1);
    localparam bit CFG_OK = (PACK >= 2) && (PACK <= 8) && (TMO_CYC >= 2);

    // A misconfigured instance elaborates this marker scope, easy to spot in the hierarchy.
    if (!CFG_OK) begin : g_bad_pack_or_timeout_config
    end

    logic [WW-1:0]     asm_q, asm_d;
    logic [CW-1:0]     asm_cnt_q, asm_cnt_d;
    logic              rd_pend_q, rd_pend_d;
    logic [WW-1:0]     out_data_q, out_data_d;
    logic [PACK-1:0]   out_be_q, out_be_d;
    logic              out_valid_q, out_valid_d;
    logic [15:0]       word_cnt_q, word_cnt_d;

    logic              rinc;
    logic              out_free;
    logic [CW:0]       inflight;
    logic [WW-1:0]     asm_with_byte;
    logic              flush_now;
    logic [WW-1:0]     part_data;
    logic [PACK-1:0]   part_be;

    assign out_free = !out_valid_q || bus.out_ready;

    // Pop whenever the bytes already held plus the one in flight leave room in the word.
    always_comb begin
        inflight = {1'b0, asm_cnt_q} + {{CW{1'b0}}, rd_pend_q};
        rinc     = !bus.empty && (inflight < (CW+1)'(PACK));
    end

    // Assembly contents with the arriving byte dropped into lane asm_cnt.
    always_comb begin
        asm_with_byte = asm_q;
        for (int i = 0; i < PACK; i++) begin
            if (CW'(i) == asm_cnt_q) begin
                asm_with_byte[i*DATA_W +: DATA_W] = bus.rdata;
            end
        end
    end

    // Partial-word view: lanes below asm_cnt are live, the rest read as zero.
    always_comb begin
        part_data = '0;
        part_be   = '0;
        for (int i = 0; i < PACK; i++) begin
            if (CW'(i) < asm_cnt_q) begin
                part_be[i]                    = 1'b1;
                part_data[i*DATA_W +: DATA_W] = asm_q[i*DATA_W +: DATA_W];
            end
        end
    end

`ifdef FIFO_RD_TMO_EN
    localparam int TW = $clog2(TMO_CYC + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYC - 1);

    logic [TW-1:0] tmo_q, tmo_d;
    logic          tmo_qual;
    logic          tmo_expired;

    // Idle timer: counts only while a partial word waits on an empty FIFO, saturates while the output is busy.
    always_comb begin
        tmo_qual    = (asm_cnt_q != '0) && (asm_cnt_q < CNT_FULL) && !rd_pend_q && bus.empty;
        tmo_expired = tmo_qual && (tmo_q >= TMO_LAST);
        flush_now   = tmo_expired && out_free;
        tmo_d       = '0;
        if (tmo_qual && !flush_now) begin
            tmo_d = tmo_expired ? TMO_LAST : tmo_q + TW'(1);
        end
    end

    // Timer register.
    always_ff @(posedge rclk or posedge rst) begin
        if (rst) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    assign flush_now = 1'b0;
`endif

    // Packing, word hand-off and handshake bookkeeping.
    always_comb begin
        asm_d       = asm_q;
        asm_cnt_d   = asm_cnt_q;
        rd_pend_d   = rinc;
        out_data_d  = out_data_q;
        out_be_d    = out_be_q;
        out_valid_d = out_valid_q;
        word_cnt_d  = word_cnt_q;

        if (out_valid_q && bus.out_ready) begin
            word_cnt_d  = word_cnt_q + 16'd1;
            out_valid_d = 1'b0;
        end

        if (asm_cnt_q == CNT_FULL) begin
            if (out_free) begin
                out_data_d  = asm_q;
                out_be_d    = '1;
                out_valid_d = 1'b1;
                asm_cnt_d   = '0;
            end
        end else if (rd_pend_q) begin
            asm_d = asm_with_byte;
            if (asm_cnt_q == CNT_LAST) begin
                if (out_free) begin
                    out_data_d  = asm_with_byte;
                    out_be_d    = '1;
                    out_valid_d = 1'b1;
                    asm_cnt_d   = '0;
                end else begin
                    asm_cnt_d   = CNT_FULL;
                end
            end else begin
                asm_cnt_d = asm_cnt_q + CW'(1);
            end
        end else if (flush_now) begin
            out_data_d  = part_data;
            out_be_d    = part_be;
            out_valid_d = 1'b1;
            asm_cnt_d   = '0;
        end
    end

    // State registers; reset discards any partial word and in-flight byte.
    always_ff @(posedge rclk or posedge rst) begin
        if (rst) begin
            asm_q       <= '0;
            asm_cnt_q   <= '0;
            rd_pend_q   <= 1'b0;
            out_data_q  <= '0;
            out_be_q    <= '0;
            out_valid_q <= 1'b0;
            word_cnt_q  <= '0;
        end else begin
            asm_q       <= asm_d;
            asm_cnt_q   <= asm_cnt_d;
            rd_pend_q   <= rd_pend_d;
            out_data_q  <= out_data_d;
            out_be_q    <= out_be_d;
            out_valid_q <= out_valid_d;
            word_cnt_q  <= word_cnt_d;
        end
    end

    assign bus.rinc      = rinc;
    assign bus.out_data  = out_data_q;
    assign bus.out_be    = out_be_q;
    assign bus.out_valid = out_valid_q;
    assign bus.word_cnt  = word_cnt_q;

endmodule
